// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that maps up to NUM_FU completions onto two registered CDB write ports.
// Optional activity counters are compiled in when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
  parameter  int NUM_FU   = 4,
  parameter  int PRF_SIZE = 64,
  parameter  int DATA_W   = 32,
  localparam int PW       = $clog2(PRF_SIZE)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][PW-1:0]      fu_prf_idx,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [1:0]                     CDB_write_en,
  output logic [1:0][PW-1:0]             CDB_write_idx,
  output logic [1:0][DATA_W-1:0]         CDB_write_data
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                    cdb_busy_cycles,
  output logic [31:0]                    cdb_full_cycles,
  output logic [31:0]                    cdb_stall_events
`endif
);

  localparam int PTRW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTRW-1:0]         r_rr_ptr;
  logic [1:0]              r_en_p1;
  logic [1:0][PW-1:0]      r_idx_p1;
  logic [1:0][DATA_W-1:0]  r_data_p1;

  logic [NUM_FU-1:0]       w_grant;
  logic                    w_has0, w_has1;
  logic [PTRW-1:0]         w_sel0, w_sel1, w_last, w_k, w_next;
  logic [PW-1:0]           w_idx0, w_idx1;
  logic [DATA_W-1:0]       w_data0, w_data1;

  // Selection: scan from rr_ptr, first two valid requesters win slots 0 and 1.
  always_comb begin
    w_grant = '0;
    w_has0  = 1'b0;
    w_has1  = 1'b0;
    w_sel0  = '0;
    w_sel1  = '0;
    w_last  = '0;
    w_k     = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      w_k = PTRW'((int'(r_rr_ptr) + j) % NUM_FU);
      if (!reset && !squash && fu_valid[w_k]) begin
        if (!w_has0) begin
          w_has0       = 1'b1;
          w_sel0       = w_k;
          w_last       = w_k;
          w_grant[w_k] = 1'b1;
        end else if (!w_has1) begin
          w_has1       = 1'b1;
          w_sel1       = w_k;
          w_last       = w_k;
          w_grant[w_k] = 1'b1;
        end
      end
    end
  end

  assign w_next   = PTRW'((int'(w_last) + 1) % NUM_FU);
  assign w_idx0   = fu_prf_idx[w_sel0];
  assign w_idx1   = fu_prf_idx[w_sel1];
  assign w_data0  = fu_data[w_sel0];
  assign w_data1  = fu_data[w_sel1];
  assign fu_ready = w_grant;

  // Broadcast stage: a winner targeting p0 keeps its slot but is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset || squash) begin
      r_en_p1   <= '0;
      r_idx_p1  <= '0;
      r_data_p1 <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_en_p1[0]   <= w_has0 && (w_idx0 != '0);
      r_en_p1[1]   <= w_has1 && (w_idx1 != '0);
      r_idx_p1[0]  <= (w_has0 && (w_idx0 != '0)) ? w_idx0  : '0;
      r_idx_p1[1]  <= (w_has1 && (w_idx1 != '0)) ? w_idx1  : '0;
      r_data_p1[0] <= (w_has0 && (w_idx0 != '0)) ? w_data0 : '0;
      r_data_p1[1] <= (w_has1 && (w_idx1 != '0)) ? w_data1 : '0;
      if (w_has0) r_rr_ptr <= w_next;
    end
  end

  assign CDB_write_en   = r_en_p1;
  assign CDB_write_idx  = r_idx_p1;
  assign CDB_write_data = r_data_p1;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] r_busy, r_full, r_stall;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [31:0] popcount(input logic [NUM_FU-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < NUM_FU; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  // Counters survive squash; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_full  <= '0;
      r_stall <= '0;
    end else begin
      r_busy <= sat_add(r_busy, {31'd0, |r_en_p1});
      r_full <= sat_add(r_full, {31'd0, &r_en_p1});
      if (!squash) r_stall <= sat_add(r_stall, popcount(fu_valid & ~w_grant));
    end
  end

  assign cdb_busy_cycles  = r_busy;
  assign cdb_full_cycles  = r_full;
  assign cdb_stall_events = r_stall;
`endif

endmodule
